// File: rtl/hpu_cmd_tracker.sv
// HPU command tracker: allocates local command slots, stamps {cluster, core, slot} IDs,
// drives a registered valid/ready command stage and retires slots on completions.
// Optional build macro HPU_CMD_TIMEOUT_EN adds per-slot age counters and sticky timeout_o flags.
module hpu_cmd_tracker #(
    parameter int unsigned NUM_HPU_CMDS = 4,
    parameter int unsigned CLUSTER_IDW  = 2,
    parameter int unsigned CORE_IDW     = 3,
    parameter int unsigned CDMA_INTF_ID = 3
`ifdef HPU_CMD_TIMEOUT_EN
    ,parameter int unsigned TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  logic [CLUSTER_IDW-1:0]                                 cluster_id_i,
    input  logic [CORE_IDW-1:0]                                    core_id_i,
    input  logic                                                   issue_valid_i,
    output logic                                                   issue_ready_o,
    input  logic [1:0]                                             issue_intf_id_i,
    input  logic [7:0]                                             issue_cmd_type_i,
    input  logic [607:0]                                           issue_descr_i,
    output logic [$clog2(NUM_HPU_CMDS)-1:0]                        issue_slot_o,
    output logic                                                   cmd_req_valid_o,
    input  logic                                                   cmd_req_ready_i,
    output logic [2+8+1+CLUSTER_IDW+CORE_IDW+$clog2(NUM_HPU_CMDS)+608-1:0] cmd_req_o,
    input  logic                                                   resp_valid_i,
    input  logic [CLUSTER_IDW+CORE_IDW+$clog2(NUM_HPU_CMDS)-1:0]   resp_cmd_id_i,
    input  logic [$clog2(NUM_HPU_CMDS)-1:0]                        poll_slot_i,
    output logic                                                   poll_done_o,
    output logic [NUM_HPU_CMDS-1:0]                                busy_o,
    output logic                                                   resp_err_o,
    output logic [31:0]                                            num_completed_o
`ifdef HPU_CMD_TIMEOUT_EN
    ,output logic [NUM_HPU_CMDS-1:0]                               timeout_o
`endif
);

    localparam int unsigned SLOTW   = $clog2(NUM_HPU_CMDS);
    localparam int unsigned CMD_IDW = CLUSTER_IDW + CORE_IDW + SLOTW;
    localparam int unsigned REQW    = 2 + 8 + 1 + CMD_IDW + 608;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } out_state_e;

    out_state_e                 state_r;
    out_state_e                 state_nxt_s;
    logic [NUM_HPU_CMDS-1:0]    busy_r;
    logic [REQW-1:0]            cmd_req_r;
    logic                       resp_err_r;
    logic [31:0]                num_completed_r;

    logic [SLOTW-1:0]           free_slot_s;
    logic                       issue_ready_s;
    logic                       issue_hs_s;
    logic                       to_uncluster_s;
    logic [CMD_IDW-1:0]         cmd_id_s;
    logic [SLOTW-1:0]           resp_slot_s;
    logic                       resp_id_match_s;
    logic                       resp_hit_s;
    logic [NUM_HPU_CMDS-1:0]    alloc_mask_s;
    logic [NUM_HPU_CMDS-1:0]    retire_mask_s;

    // Lowest-index clear bit of the busy map; callers only use it while a free slot exists.
    function automatic logic [SLOTW-1:0] lowest_free(input logic [NUM_HPU_CMDS-1:0] busy);
        lowest_free = {SLOTW{1'b0}};
        for (int i = NUM_HPU_CMDS - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                lowest_free = SLOTW'(i);
            end
        end
    endfunction

    // Issue-side handshake, allocation and command ID stamping.
    always_comb begin
        free_slot_s    = lowest_free(busy_r);
        issue_ready_s  = (busy_r != {NUM_HPU_CMDS{1'b1}}) &&
                         ((state_r == ST_IDLE) || cmd_req_ready_i);
        issue_hs_s     = issue_valid_i && issue_ready_s;
        to_uncluster_s = (issue_intf_id_i != 2'(CDMA_INTF_ID));
        cmd_id_s       = {cluster_id_i, core_id_i, free_slot_s};
        alloc_mask_s   = {NUM_HPU_CMDS{1'b0}};
        if (issue_hs_s) begin
            alloc_mask_s[free_slot_s] = 1'b1;
        end else begin
            alloc_mask_s = {NUM_HPU_CMDS{1'b0}};
        end
    end

    // Response decode: a completion retires only a busy slot owned by this cluster/core.
    always_comb begin
        resp_slot_s     = resp_cmd_id_i[SLOTW-1:0];
        resp_id_match_s = (resp_cmd_id_i[CMD_IDW-1 -: CLUSTER_IDW] == cluster_id_i) &&
                          (resp_cmd_id_i[SLOTW +: CORE_IDW] == core_id_i);
        resp_hit_s      = resp_valid_i && resp_id_match_s && busy_r[resp_slot_s];
        retire_mask_s   = {NUM_HPU_CMDS{1'b0}};
        if (resp_hit_s) begin
            retire_mask_s[resp_slot_s] = 1'b1;
        end else begin
            retire_mask_s = {NUM_HPU_CMDS{1'b0}};
        end
    end

    // Output stage next state; HOLD->HOLD on ready plus new handshake keeps 1 cmd/cycle.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (issue_hs_s) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cmd_req_ready_i && !issue_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output stage state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command register; only a handshake reloads it, so it is stable under backpressure.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cmd_req_r <= {REQW{1'b0}};
        end else if (issue_hs_s) begin
            cmd_req_r <= {issue_intf_id_i, issue_cmd_type_i, to_uncluster_s, cmd_id_s, issue_descr_i};
        end
    end

    // Slot bookkeeping: allocation and retirement always target distinct slots.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_r          <= {NUM_HPU_CMDS{1'b0}};
            resp_err_r      <= 1'b0;
            num_completed_r <= 32'd0;
        end else begin
            busy_r     <= (busy_r & ~retire_mask_s) | alloc_mask_s;
            resp_err_r <= resp_valid_i && !resp_hit_s;
            if (resp_hit_s) begin
                num_completed_r <= num_completed_r + 32'd1;
            end
        end
    end

`ifdef HPU_CMD_TIMEOUT_EN
    logic [15:0]             age_r [NUM_HPU_CMDS];
    logic [NUM_HPU_CMDS-1:0] timeout_r;

    // Per-slot age counters and sticky timeout flags.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_HPU_CMDS; i++) begin
                age_r[i] <= 16'd0;
            end
            timeout_r <= {NUM_HPU_CMDS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_HPU_CMDS; i++) begin
                if (alloc_mask_s[i]) begin
                    age_r[i] <= 16'd0;
                end else if (busy_r[i] && (age_r[i] != 16'hFFFF)) begin
                    age_r[i] <= age_r[i] + 16'd1;
                end
                if (retire_mask_s[i]) begin
                    timeout_r[i] <= 1'b0;
                end else if (busy_r[i] && (age_r[i] >= 16'(TIMEOUT_CYCLES))) begin
                    timeout_r[i] <= 1'b1;
                end
            end
        end
    end

    assign timeout_o = timeout_r;
`endif

    assign issue_ready_o   = issue_ready_s;
    assign issue_slot_o    = free_slot_s;
    assign cmd_req_valid_o = (state_r == ST_HOLD);
    assign cmd_req_o       = cmd_req_r;
    assign poll_done_o     = !busy_r[poll_slot_i];
    assign busy_o          = busy_r;
    assign resp_err_o      = resp_err_r;
    assign num_completed_o = num_completed_r;

endmodule

// File: tb/tb_hpu_cmd_tracker.sv
// Directed self-checking bench for hpu_cmd_tracker (default build, 4 slots).
module tb_hpu_cmd_tracker;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [1:0]   cluster_id_i;
    logic [2:0]   core_id_i;
    logic         issue_valid_i;
    logic         issue_ready_o;
    logic [1:0]   issue_intf_id_i;
    logic [7:0]   issue_cmd_type_i;
    logic [607:0] issue_descr_i;
    logic [1:0]   issue_slot_o;
    logic         cmd_req_valid_o;
    logic         cmd_req_ready_i;
    logic [625:0] cmd_req_o;
    logic         resp_valid_i;
    logic [6:0]   resp_cmd_id_i;
    logic [1:0]   poll_slot_i;
    logic         poll_done_o;
    logic [3:0]   busy_o;
    logic         resp_err_o;
    logic [31:0]  num_completed_o;

    int checks = 0;
    int errors = 0;
    logic [31:0]  exp_done = 32'd0;
    logic [625:0] exp_req;

    hpu_cmd_tracker dut (
        .clk_i(clk_i), .rst_i(rst_i), .cluster_id_i(cluster_id_i), .core_id_i(core_id_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_intf_id_i(issue_intf_id_i), .issue_cmd_type_i(issue_cmd_type_i),
        .issue_descr_i(issue_descr_i), .issue_slot_o(issue_slot_o),
        .cmd_req_valid_o(cmd_req_valid_o), .cmd_req_ready_i(cmd_req_ready_i),
        .cmd_req_o(cmd_req_o), .resp_valid_i(resp_valid_i), .resp_cmd_id_i(resp_cmd_id_i),
        .poll_slot_i(poll_slot_i), .poll_done_o(poll_done_o), .busy_o(busy_o),
        .resp_err_o(resp_err_o), .num_completed_o(num_completed_o)
    );

    always #5 clk_i = ~clk_i;

    // cluster=2, core=5 -> cmd_id = 7'b10_101_ss = 0x54 | slot
    function automatic logic [6:0] id_of(input logic [1:0] slot);
        return {2'b10, 3'b101, slot};
    endfunction

    function automatic logic [625:0] mk_req(input logic [1:0] intf, input logic [7:0] ty,
                                            input logic tou, input logic [1:0] slot,
                                            input logic [607:0] d);
        return {intf, ty, tou, id_of(slot), d};
    endfunction

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    // Retire one slot with a correct response and expect no error.
    task automatic retire(input logic [1:0] slot);
        resp_valid_i  = 1'b1;
        resp_cmd_id_i = id_of(slot);
        step();
        resp_valid_i  = 1'b0;
        exp_done      = exp_done + 32'd1;
        checks++;
        if (num_completed_o !== exp_done || resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL retire slot %0d: done=%0d err=%b, want done=%0d err=0",
                     slot, num_completed_o, resp_err_o, exp_done);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        #3;
        checks++;
        if (busy_o !== 4'b0000 || cmd_req_valid_o !== 1'b0 || cmd_req_o !== 626'd0 ||
            resp_err_o !== 1'b0 || num_completed_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b err=%b done=%0d, want 0000/0/0/0",
                     busy_o, cmd_req_valid_o, resp_err_o, num_completed_o);
        end
        step();
        rst_i = 1'b0;
        #1;
        checks++;
        if (issue_ready_o !== 1'b1 || issue_slot_o !== 2'd0 || poll_done_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_issue: ready=%b slot=%0d poll=%b, want 1/0/1",
                     issue_ready_o, issue_slot_o, poll_done_o);
        end
    endtask

    task automatic test_first_issue;
        cmd_req_ready_i  = 1'b1;
        issue_valid_i    = 1'b1;
        issue_intf_id_i  = 2'd1;
        issue_cmd_type_i = 8'h05;
        issue_descr_i    = {19{32'hDEAD_BEEF}};
        exp_req          = mk_req(2'd1, 8'h05, 1'b1, 2'd0, {19{32'hDEAD_BEEF}});
        #1;
        checks++;
        if (issue_ready_o !== 1'b1 || issue_slot_o !== 2'd0) begin
            errors++;
            $display("FAIL first_alloc: ready=%b slot=%0d, want 1/0", issue_ready_o, issue_slot_o);
        end
        step();
        issue_valid_i = 1'b0;
        checks++;
        if (cmd_req_valid_o !== 1'b1 || cmd_req_o !== exp_req || busy_o !== 4'b0001) begin
            errors++;
            $display("FAIL first_req: valid=%b busy=%b hdr=%h, want 1/0001/%h",
                     cmd_req_valid_o, busy_o, cmd_req_o[625:608], exp_req[625:608]);
        end
        step();
        checks++;
        if (cmd_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL first_drain: valid=%b, want 0", cmd_req_valid_o);
        end
        retire(2'd0);
    endtask

    task automatic test_fill;
        cmd_req_ready_i  = 1'b1;
        issue_intf_id_i  = 2'd0;
        issue_cmd_type_i = 8'h11;
        for (int i = 0; i < 4; i++) begin
            issue_valid_i = 1'b1;
            #1;
            checks++;
            if (issue_ready_o !== 1'b1 || issue_slot_o !== 2'(i)) begin
                errors++;
                $display("FAIL fill_alloc%0d: ready=%b slot=%0d, want 1/%0d",
                         i, issue_ready_o, issue_slot_o, i);
            end
            step();
        end
        checks++;
        if (issue_ready_o !== 1'b0 || busy_o !== 4'b1111) begin
            errors++;
            $display("FAIL fill_full: ready=%b busy=%b, want 0/1111", issue_ready_o, busy_o);
        end
        step();
        issue_valid_i = 1'b0;
        checks++;
        if (busy_o !== 4'b1111 || cmd_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fill_reject: busy=%b valid=%b, want 1111/0", busy_o, cmd_req_valid_o);
        end
        resp_valid_i  = 1'b1;
        resp_cmd_id_i = id_of(2'd2);
        #1;
        checks++;
        if (issue_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL free_same_cycle: ready=%b, want 0", issue_ready_o);
        end
        step();
        resp_valid_i = 1'b0;
        exp_done     = exp_done + 32'd1;
        poll_slot_i  = 2'd2;
        #1;
        checks++;
        if (issue_ready_o !== 1'b1 || issue_slot_o !== 2'd2 || busy_o !== 4'b1011 ||
            num_completed_o !== exp_done || poll_done_o !== 1'b1) begin
            errors++;
            $display("FAIL free_next: ready=%b slot=%0d busy=%b done=%0d poll=%b, want 1/2/1011/%0d/1",
                     issue_ready_o, issue_slot_o, busy_o, num_completed_o, poll_done_o, exp_done);
        end
        poll_slot_i = 2'd1;
        #1;
        checks++;
        if (poll_done_o !== 1'b0) begin
            errors++;
            $display("FAIL poll_busy: poll=%b, want 0", poll_done_o);
        end
        issue_valid_i = 1'b1;
        step();
        issue_valid_i = 1'b0;
        checks++;
        if (busy_o !== 4'b1111 || cmd_req_o[614:608] !== id_of(2'd2)) begin
            errors++;
            $display("FAIL realloc: busy=%b id=%h, want 1111/%h", busy_o, cmd_req_o[614:608], id_of(2'd2));
        end
        step();
        for (int i = 0; i < 4; i++) begin
            retire(2'(i));
        end
    endtask

    task automatic test_backpressure;
        cmd_req_ready_i  = 1'b0;
        issue_valid_i    = 1'b1;
        issue_intf_id_i  = 2'd2;
        issue_cmd_type_i = 8'h33;
        issue_descr_i    = {19{32'h1234_5678}};
        exp_req          = mk_req(2'd2, 8'h33, 1'b1, 2'd0, {19{32'h1234_5678}});
        step();
        issue_cmd_type_i = 8'h44;
        issue_descr_i    = {19{32'h0F0F_0F0F}};
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (cmd_req_valid_o !== 1'b1 || cmd_req_o !== exp_req || issue_ready_o !== 1'b0 ||
                busy_o !== 4'b0001) begin
                errors++;
                $display("FAIL hold%0d: valid=%b ready=%b busy=%b hdr=%h, want 1/0/0001/%h",
                         i, cmd_req_valid_o, issue_ready_o, busy_o, cmd_req_o[625:608], exp_req[625:608]);
            end
            step();
        end
        issue_valid_i   = 1'b0;
        cmd_req_ready_i = 1'b1;
        step();
        checks++;
        if (cmd_req_valid_o !== 1'b0 || busy_o !== 4'b0001) begin
            errors++;
            $display("FAIL release: valid=%b busy=%b, want 0/0001", cmd_req_valid_o, busy_o);
        end
        retire(2'd0);
    endtask

    task automatic test_back_to_back;
        cmd_req_ready_i  = 1'b1;
        issue_valid_i    = 1'b1;
        issue_intf_id_i  = 2'd0;
        issue_cmd_type_i = 8'hA1;
        step();
        checks++;
        if (cmd_req_valid_o !== 1'b1 || cmd_req_o[623:608] !== {8'hA1, 1'b1, id_of(2'd0)} ||
            issue_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: valid=%b ready=%b hdr=%h", cmd_req_valid_o, issue_ready_o, cmd_req_o[623:608]);
        end
        issue_cmd_type_i = 8'hB2;
        step();
        issue_valid_i = 1'b0;
        checks++;
        if (cmd_req_valid_o !== 1'b1 || cmd_req_o[623:608] !== {8'hB2, 1'b1, id_of(2'd1)} ||
            busy_o !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_second: valid=%b busy=%b hdr=%h", cmd_req_valid_o, busy_o, cmd_req_o[623:608]);
        end
        step();
        checks++;
        if (cmd_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, want 0", cmd_req_valid_o);
        end
        retire(2'd0);
        retire(2'd1);
    endtask

    task automatic test_cdma_and_errors;
        cmd_req_ready_i = 1'b1;
        issue_valid_i   = 1'b1;
        issue_intf_id_i = 2'd3;
        step();
        issue_valid_i = 1'b0;
        checks++;
        if (cmd_req_o[615] !== 1'b0 || cmd_req_o[625:624] !== 2'd3 || busy_o !== 4'b0001) begin
            errors++;
            $display("FAIL cdma: to_uncluster=%b intf=%0d busy=%b, want 0/3/0001",
                     cmd_req_o[615], cmd_req_o[625:624], busy_o);
        end
        resp_valid_i  = 1'b1;
        resp_cmd_id_i = {2'b10, 3'b100, 2'b00};
        step();
        resp_valid_i = 1'b0;
        checks++;
        if (resp_err_o !== 1'b1 || busy_o !== 4'b0001 || num_completed_o !== exp_done) begin
            errors++;
            $display("FAIL bad_core: err=%b busy=%b done=%0d, want 1/0001/%0d",
                     resp_err_o, busy_o, num_completed_o, exp_done);
        end
        step();
        checks++;
        if (resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: err=%b, want 0", resp_err_o);
        end
        resp_valid_i  = 1'b1;
        resp_cmd_id_i = id_of(2'd1);
        step();
        resp_valid_i = 1'b0;
        checks++;
        if (resp_err_o !== 1'b1 || busy_o !== 4'b0001 || num_completed_o !== exp_done) begin
            errors++;
            $display("FAIL idle_slot: err=%b busy=%b done=%0d, want 1/0001/%0d",
                     resp_err_o, busy_o, num_completed_o, exp_done);
        end
        resp_valid_i  = 1'b1;
        resp_cmd_id_i = {2'b01, 3'b101, 2'b00};
        step();
        resp_valid_i = 1'b0;
        checks++;
        if (resp_err_o !== 1'b1 || busy_o !== 4'b0001) begin
            errors++;
            $display("FAIL bad_cluster: err=%b busy=%b, want 1/0001", resp_err_o, busy_o);
        end
        retire(2'd0);
    endtask

    task automatic test_alloc_retire;
        cmd_req_ready_i = 1'b1;
        issue_valid_i   = 1'b1;
        issue_intf_id_i = 2'd1;
        step();
        step();
        issue_valid_i = 1'b0;
        retire(2'd0);
        checks++;
        if (busy_o !== 4'b0010) begin
            errors++;
            $display("FAIL ar_setup: busy=%b, want 0010", busy_o);
        end
        issue_valid_i = 1'b1;
        resp_valid_i  = 1'b1;
        resp_cmd_id_i = id_of(2'd1);
        #1;
        checks++;
        if (issue_slot_o !== 2'd0 || issue_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ar_alloc: slot=%0d ready=%b, want 0/1", issue_slot_o, issue_ready_o);
        end
        step();
        issue_valid_i = 1'b0;
        resp_valid_i  = 1'b0;
        exp_done      = exp_done + 32'd1;
        checks++;
        if (busy_o !== 4'b0001 || num_completed_o !== exp_done || resp_err_o !== 1'b0) begin
            errors++;
            $display("FAIL ar_both: busy=%b done=%0d err=%b, want 0001/%0d/0",
                     busy_o, num_completed_o, resp_err_o, exp_done);
        end
        step();
        retire(2'd0);
    endtask

    task automatic test_reset_mid;
        cmd_req_ready_i = 1'b0;
        issue_valid_i   = 1'b1;
        step();
        issue_valid_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        checks++;
        if (cmd_req_valid_o !== 1'b0 || busy_o !== 4'b0000 || cmd_req_o !== 626'd0 ||
            num_completed_o !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b busy=%b done=%0d, want 0/0000/0",
                     cmd_req_valid_o, busy_o, num_completed_o);
        end
        #2;
        rst_i           = 1'b0;
        cmd_req_ready_i = 1'b1;
        step();
        checks++;
        if (issue_ready_o !== 1'b1 || issue_slot_o !== 2'd0) begin
            errors++;
            $display("FAIL after_reset: ready=%b slot=%0d, want 1/0", issue_ready_o, issue_slot_o);
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        cluster_id_i     = 2'b10;
        core_id_i        = 3'b101;
        issue_valid_i    = 1'b0;
        issue_intf_id_i  = 2'd0;
        issue_cmd_type_i = 8'h00;
        issue_descr_i    = 608'd0;
        cmd_req_ready_i  = 1'b1;
        resp_valid_i     = 1'b0;
        resp_cmd_id_i    = 7'd0;
        poll_slot_i      = 2'd0;
        test_reset();
        test_first_issue();
        test_fill();
        test_backpressure();
        test_back_to_back();
        test_cdma_and_errors();
        test_alloc_retire();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
